// File: rtl/io_arbiter.sv
// io_arbiter: round-robin share of one ioctrl-style IO bus between two masters,
// one transaction in flight, registered bus drive and a ready timeout.
`ifndef IO_ADDR_WIDTH
`define IO_ADDR_WIDTH 16
`endif
`ifndef IO_DATA_WIDTH
`define IO_DATA_WIDTH 8
`endif

module io_arbiter #(
   parameter int ADDR_WIDTH = `IO_ADDR_WIDTH,
   parameter int DATA_WIDTH = `IO_DATA_WIDTH,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   input  logic                  m0_read,
   input  logic                  m0_write,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic                  m0_ready,
   output logic                  m0_err,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   input  logic                  m1_read,
   input  logic                  m1_write,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  m1_ready,
   output logic                  m1_err,
   output logic [ADDR_WIDTH-1:0] io_addr,
   inout  wire  [DATA_WIDTH-1:0] io_data,
   output logic                  io_read,
   output logic                  io_write,
   input  logic                  io_ready,
   output logic                  busy,
   output logic                  grant
);

   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [1:0] S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2;

   logic [1:0]            r_state;
   logic                  r_grant, r_last, r_io_read, r_io_write;
   logic                  r_m0_ready, r_m1_ready, r_m0_err, r_m1_err;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata, r_m0_rdata, r_m1_rdata;
   logic [CW-1:0]         r_cnt;
   logic                  w_req0, w_req1, w_sel, w_wr, w_done;
   logic [DATA_WIDTH-1:0] w_rdata;

   assign w_req0  = m0_read | m0_write;
   assign w_req1  = m1_read | m1_write;
   // on contention the master that did not win last time goes next
   assign w_sel   = (w_req0 & w_req1) ? ~r_last : w_req1;
   assign w_wr    = w_sel ? m1_write : m0_write;
   assign w_done  = io_ready | (r_cnt == CW'(TIMEOUT - 1));
   assign w_rdata = io_ready ? io_data : '1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_grant    <= 1'b0;
         r_last     <= 1'b1;
         r_io_read  <= 1'b0;
         r_io_write <= 1'b0;
         r_m0_ready <= 1'b0;
         r_m1_ready <= 1'b0;
         r_m0_err   <= 1'b0;
         r_m1_err   <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_m0_rdata <= '0;
         r_m1_rdata <= '0;
         r_cnt      <= '0;
      end else begin
         r_m0_ready <= 1'b0;
         r_m1_ready <= 1'b0;
         r_m0_err   <= 1'b0;
         r_m1_err   <= 1'b0;
         if (r_state == S_IDLE) begin
            if (w_req0 | w_req1) begin
               r_grant    <= w_sel;
               r_addr     <= w_sel ? m1_addr : m0_addr;
               r_wdata    <= w_sel ? m1_wdata : m0_wdata;
               r_io_read  <= ~w_wr;
               r_io_write <= w_wr;
               r_cnt      <= '0;
               r_state    <= S_ACCESS;
            end
         end else if (r_state == S_ACCESS) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_done) begin
               r_io_read  <= 1'b0;
               r_io_write <= 1'b0;
               r_m0_ready <= ~r_grant;
               r_m1_ready <= r_grant;
               r_m0_err   <= ~r_grant & ~io_ready;
               r_m1_err   <= r_grant & ~io_ready;
               if (r_io_read & ~r_grant) r_m0_rdata <= w_rdata;
               if (r_io_read & r_grant) r_m1_rdata <= w_rdata;
               r_state    <= S_RESP;
            end
         end else begin
            r_last  <= r_grant;
            r_cnt   <= '0;
            r_state <= S_IDLE;
         end
      end
   end

   assign io_addr  = r_addr;
   assign io_data  = r_io_write ? r_wdata : 'z;
   assign io_read  = r_io_read;
   assign io_write = r_io_write;
   assign busy     = r_state != S_IDLE;
   assign grant    = r_grant;
   assign m0_rdata = r_m0_rdata;
   assign m1_rdata = r_m1_rdata;
   assign m0_ready = r_m0_ready;
   assign m1_ready = r_m1_ready;
   assign m0_err   = r_m0_err;
   assign m1_err   = r_m1_err;

endmodule
